// File: rtl/mult_share_pkg.sv
// Shared helpers for the multiplier-sharing arbiter: ID width and product width derivation.
package mult_share_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned id_width(input int unsigned num_req);
    return clog2(num_req);
  endfunction

  function automatic int unsigned prod_width(input int unsigned width_a,
                                             input int unsigned width_b);
    return width_a + width_b;
  endfunction

endpackage

// File: rtl/normal_multiplier.sv
// Combinational unsigned shift-add multiplier, full-width product.
module normal_multiplier
  import mult_share_pkg::*;
#(
  parameter int unsigned WIDTH_A = 8,
  parameter int unsigned WIDTH_B = 8
) (
  input  logic [WIDTH_A-1:0]                        a_i,
  input  logic [WIDTH_B-1:0]                        b_i,
  output logic [prod_width(WIDTH_A, WIDTH_B)-1:0]   m_o
);

  localparam int unsigned PW = prod_width(WIDTH_A, WIDTH_B);

  logic [PW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < WIDTH_B; i++) begin
      if (b_i[i]) acc = acc + (PW'(a_i) << i);
    end
    m_o = acc;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid request at or above the pointer, wrapping.
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int unsigned IdW = id_width(NUM_REQ);

  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] sel;
  logic           found;
  int unsigned    idx;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    if (en_i) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        idx = 32'(ptr_q) + off;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        sel = IdW'(idx);
        if (!found && req_i[sel]) begin
          found      = 1'b1;
          gnt_o[sel] = 1'b1;
          ptr_d      = (idx == NUM_REQ - 1) ? '0 : IdW'(idx + 1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one multiplier among NUM_REQ requesters; results are broadcast tagged with the
// requester ID after LATENCY enabled cycles.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int unsigned WIDTH_A = 8,
  parameter int unsigned WIDTH_B = 8,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    en_i,
  input  logic [NUM_REQ-1:0]                      req_valid_i,
  output logic [NUM_REQ-1:0]                      req_ready_o,
  input  logic [NUM_REQ*WIDTH_A-1:0]              req_a_i,
  input  logic [NUM_REQ*WIDTH_B-1:0]              req_b_i,
  output logic                                    res_valid_o,
  output logic [id_width(NUM_REQ)-1:0]            res_id_o,
  output logic [prod_width(WIDTH_A, WIDTH_B)-1:0] res_m_o,
  output logic                                    busy_o
);

  localparam int unsigned ID_W = id_width(NUM_REQ);
  localparam int unsigned PW   = prod_width(WIDTH_A, WIDTH_B);
  localparam int unsigned NStg = (LATENCY > 1) ? LATENCY - 1 : 1;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic [WIDTH_A-1:0] gnt_a;
  logic [WIDTH_B-1:0] gnt_b;

  logic               s0_valid_q;
  logic [ID_W-1:0]    s0_id_q;
  logic [WIDTH_A-1:0] s0_a_q;
  logic [WIDTH_B-1:0] s0_b_q;
  logic [PW-1:0]      mul_m;

  logic               last_valid;
  logic [ID_W-1:0]    last_id;
  logic [PW-1:0]      last_m;
  logic               stg_busy;

  logic [ID_W-1:0]    hold_id_q;
  logic [PW-1:0]      hold_m_q;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (en_i),
    .req_i (req_valid_i),
    .gnt_o (gnt)
  );

  assign req_ready_o = gnt;

  // Grant is one-hot or zero, so a priority-free encode/mux is sufficient.
  always_comb begin
    gnt_id = '0;
    gnt_a  = '0;
    gnt_b  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_id = ID_W'(i);
        gnt_a  = req_a_i[i*WIDTH_A +: WIDTH_A];
        gnt_b  = req_b_i[i*WIDTH_B +: WIDTH_B];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_valid_q <= 1'b0;
      s0_id_q    <= '0;
      s0_a_q     <= '0;
      s0_b_q     <= '0;
    end else if (en_i) begin
      s0_valid_q <= |gnt;
      if (|gnt) begin
        s0_id_q <= gnt_id;
        s0_a_q  <= gnt_a;
        s0_b_q  <= gnt_b;
      end
    end
  end

  normal_multiplier #(
    .WIDTH_A(WIDTH_A),
    .WIDTH_B(WIDTH_B)
  ) u_mul (
    .a_i(s0_a_q),
    .b_i(s0_b_q),
    .m_o(mul_m)
  );

  if (LATENCY > 1) begin : g_pipe
    logic [NStg-1:0] pv_q;
    logic [ID_W-1:0] pid_q [NStg];
    logic [PW-1:0]   pm_q  [NStg];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pv_q <= '0;
        for (int k = 0; k < NStg; k++) begin
          pid_q[k] <= '0;
          pm_q[k]  <= '0;
        end
      end else if (en_i) begin
        pv_q[0] <= s0_valid_q;
        if (s0_valid_q) begin
          pid_q[0] <= s0_id_q;
          pm_q[0]  <= mul_m;
        end
        for (int k = 1; k < NStg; k++) begin
          pv_q[k] <= pv_q[k-1];
          if (pv_q[k-1]) begin
            pid_q[k] <= pid_q[k-1];
            pm_q[k]  <= pm_q[k-1];
          end
        end
      end
    end

    assign last_valid = pv_q[NStg-1];
    assign last_id    = pid_q[NStg-1];
    assign last_m     = pm_q[NStg-1];
    assign stg_busy   = |pv_q;
  end else begin : g_direct
    assign last_valid = s0_valid_q;
    assign last_id    = s0_id_q;
    assign last_m     = mul_m;
    assign stg_busy   = 1'b0;
  end

  assign res_valid_o = last_valid & en_i;

  // Remember the last presented result so the bus is stable between strobes and stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_id_q <= '0;
      hold_m_q  <= '0;
    end else if (res_valid_o) begin
      hold_id_q <= last_id;
      hold_m_q  <= last_m;
    end
  end

  assign res_id_o = res_valid_o ? last_id : hold_id_q;
  assign res_m_o  = res_valid_o ? last_m : hold_m_q;
  assign busy_o   = s0_valid_q | stg_busy;

endmodule
